// File: rtl/mul_pipe_unit.sv
// RV32M multiply pipe (MUL/MULH/MULHSU/MULHU): one op per cycle, result after STAGES cycles.
// No backpressure: hold_i freezes every stage, flush_i empties the pipe and wins over hold.
module mul_pipe_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [1:0]      op_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] ra_i,
  input  logic [XLEN-1:0] rb_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic [4:0]      hazard_rd_i,
  output logic            hazard_o,
  output logic            busy_o,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_value_o
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("mul_pipe_unit: STAGES must be in 2..4");
  end

  logic            accept;
  logic            a_sign;
  logic            b_sign;
  logic [XLEN:0]   a_q;
  logic [XLEN:0]   b_q;
  logic            hi_q;
  logic [STAGES:1] vld_q;
  logic [4:0]      rd_q  [1:STAGES];
  logic [XLEN-1:0] val_q [2:STAGES];
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] result;
  logic            hit;

  assign accept = valid_i & ~hold_i & ~flush_i;
  assign a_sign = ra_i[XLEN-1] & ((op_i == 2'b01) | (op_i == 2'b10));
  assign b_sign = rb_i[XLEN-1] & (op_i == 2'b01);

  // Only the low 2*XLEN product bits are ever selected, so sign-extending the
  // XLEN+1-bit operands to 2*XLEN and truncating gives the same bits.
  assign prod   = {{(XLEN-1){a_q[XLEN]}}, a_q} * {{(XLEN-1){b_q[XLEN]}}, b_q};
  assign result = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= 1'b0;
      vld_q <= '0;
      for (int s = 1; s <= STAGES; s++) rd_q[s] <= '0;
      for (int s = 2; s <= STAGES; s++) val_q[s] <= '0;
    end else if (flush_i) begin
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= 1'b0;
      vld_q <= '0;
      for (int s = 1; s <= STAGES; s++) rd_q[s] <= '0;
      for (int s = 2; s <= STAGES; s++) val_q[s] <= '0;
    end else if (!hold_i) begin
      a_q      <= accept ? {a_sign, ra_i} : '0;
      b_q      <= accept ? {b_sign, rb_i} : '0;
      hi_q     <= accept && (op_i != 2'b00);
      vld_q[1] <= accept;
      rd_q[1]  <= accept ? rd_i : 5'd0;
      vld_q[2] <= vld_q[1];
      rd_q[2]  <= vld_q[1] ? rd_q[1] : 5'd0;
      val_q[2] <= vld_q[1] ? result : '0;
      for (int s = 3; s <= STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        rd_q[s]  <= rd_q[s-1];
        val_q[s] <= val_q[s-1];
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int s = 1; s <= STAGES; s++) begin
      if (vld_q[s] && (rd_q[s] == hazard_rd_i)) hit = 1'b1;
    end
  end

  assign hazard_o   = hit & (hazard_rd_i != 5'd0);
  assign busy_o     = |vld_q;
  assign wb_valid_o = vld_q[STAGES];
  assign wb_rd_o    = rd_q[STAGES];
  assign wb_value_o = val_q[STAGES];

endmodule

// File: doc/mul_pipe_unit.md
# mul_pipe_unit

Parametrised, fully pipelined RV32M multiply unit for the execute path: MUL, MULH, MULHSU, MULHU. It sits beside the ALU, accepts one operation per cycle and returns the result with its destination register tag after STAGES cycles. Per-stage valid and tag tracking, pipeline flush, and a register-hazard query let the issue logic interlock against in-flight multiplies.

## Interface
- XLEN, 32 — operand/result width.
- STAGES, 2 — accept-to-writeback latency in cycles; legal 2..4, anything else is an elaboration error.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  operation present this cycle.
- op_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- rd_i  in  5  destination register index.
- ra_i  in  XLEN  rs1 operand.
- rb_i  in  XLEN  rs2 operand.
- hold_i  in  1  pipeline stall, freezes all stages.
- flush_i  in  1  kill all in-flight operations.
- hazard_rd_i  in  5  register index queried by issue logic.
- hazard_o  out  1  an in-flight op writes hazard_rd_i (combinational).
- busy_o  out  1  any stage valid.
- wb_valid_o  out  1  result valid.
- wb_rd_o  out  5  result destination.
- wb_value_o  out  XLEN  result.

## Operation
- Operand extension to XLEN+1 bits at accept:
  - MULH: both operands signed.
  - MULHSU: ra signed, rb zero-extended.
  - MUL and MULHU: both zero-extended.
- Product is the signed (2·XLEN+2)-bit product of the extended operands.
  - MUL selects bits [XLEN-1:0]; all other ops select [2·XLEN-1:XLEN].
- Stage 1 registers the extended operands, hi-select, rd and valid.
- The multiply is combinational between stage 1 and stage 2. Stage 2 registers the selected XLEN result, rd and valid.
- Stages 3..STAGES are delay registers for value, rd and valid. The last stage drives the wb_* outputs.
- Accept occurs when valid_i=1, hold_i=0 and flush_i=0. No ready output: the unit always accepts when not held.
- Bubble: a stage receiving no valid op loads value 0, rd 0, valid 0. wb_value_o is therefore 0 whenever wb_valid_o=0.
- hold_i=1 and flush_i=0: every stage keeps its contents; valid_i is ignored; wb_* outputs stay constant.
- flush_i=1: all valid bits, values and rds clear at the next edge. This applies regardless of hold_i or valid_i; flush wins.
- hazard_o=1 iff hazard_rd_i≠0 and some stage s has valid=1 and rd=hazard_rd_i. The output stage is included.
- busy_o = OR of all stage valid bits.
- rd_i=0 is accepted and written back normally (wb_rd_o=0). It never raises hazard_o.

## Timing
- Reset values: wb_valid_o=0, wb_rd_o=0, wb_value_o=0, busy_o=0, hazard_o=0; all stage registers 0.
- Latency: an op accepted at edge N appears on wb_* after edge N+STAGES−1, i.e. STAGES cycles after valid_i is presented. Held cycles add one each.
- Throughput: 1 op/cycle. Back-to-back ops exit in order on consecutive cycles.
- wb_valid_o is a one-cycle pulse per op, except while held, when it persists.
- Flush is not selective: an op at the output stage on a flush cycle is still visible that cycle and gone the next.
- Reset deassertion mid-stream: pipeline empty; nothing is emitted for ops presented before reset.

## Test plan
- Basic MUL, STAGES=2: MUL, ra=7, rb=6, rd=5 → 2 cycles later wb_valid_o=1, wb_rd_o=5, wb_value_o=42; 0 on all other cycles.
- Signedness, four consecutive ops:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
  - Results emerge on four consecutive cycles, in order.
- Hold, STAGES=3: issue 3 ops back-to-back, then hold_i=1 for 4 cycles mid-stream → wb_* frozen during hold; results appear in order with latency 3+4; no op lost or duplicated.
- Flush: 2 ops in flight; flush_i=1 together with a new valid_i → next cycle busy_o=0, wb_valid_o=0; the new op is never emitted.
- Hazard: MUL rd=9 in flight; hazard_rd_i=9 → hazard_o=1 until the cycle after writeback. hazard_rd_i=0 with an rd=0 op in flight → hazard_o=0.
- Reset mid-operation: assert rst_i asynchronously with 2 ops in flight → all outputs 0 immediately; no writeback after release.
